// File: rtl/id_hazard_ctrl_pip.sv
// Decode-stage control: owns the ID/EX register, stalls the front end on load-use
// hazards, redirects on JAL in ID and forwards EX-stage redirects to fetch.
module id_hazard_ctrl_pip #(
   parameter int          LOAD_USE_STALL = 1,
   parameter logic [31:0] NOP_INSTR      = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr_in,
   input  logic [31:0] pc_in,
   input  logic        ex_redirect,
   input  logic [31:0] ex_target,
   output logic        pc_write,
   output logic        if_id_write,
   output logic        if_id_flush,
   output logic        jump,
   output logic [31:0] jump_target,
   output logic        branch_taken,
   output logic [31:0] branch_target,
   output logic        idex_valid,
   output logic [31:0] idex_instr,
   output logic [31:0] idex_pc
);

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_JAL   = 7'b1101111;
   localparam logic [6:0] OPC_BR    = 7'b1100011;
   localparam logic [6:0] OPC_ST    = 7'b0100011;
   localparam logic [6:0] OPC_R     = 7'b0110011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

   localparam logic [2:0] STALL_INIT = 3'(LOAD_USE_STALL - 1);

   typedef enum logic {RUN, STALL} state_t;

   state_t     state, state_nxt;
   logic [2:0] cnt, cnt_nxt;

   logic [6:0] opc, idex_opc;
   logic [4:0] rs1, rs2, idex_rd;
   logic       rs1_used, rs2_used, hazard, stall, jal_id;

   assign opc      = instr_in[6:0];
   assign rs1      = instr_in[19:15];
   assign rs2      = instr_in[24:20];
   assign idex_opc = idex_instr[6:0];
   assign idex_rd  = idex_instr[11:7];

   assign rs1_used = (opc != OPC_LUI) && (opc != OPC_AUIPC) && (opc != OPC_JAL);
   assign rs2_used = (opc == OPC_R) || (opc == OPC_ST) || (opc == OPC_BR);

   assign hazard = (state == RUN) && idex_valid && (idex_opc == OPC_LOAD) && (idex_rd != 5'd0) &&
                   ((rs1_used && rs1 == idex_rd) || (rs2_used && rs2 == idex_rd));
   assign stall  = hazard || (state == STALL);
   assign jal_id = (opc == OPC_JAL);

   assign jump_target   = pc_in + {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                                   instr_in[20], instr_in[30:21], 1'b0};
   assign branch_taken  = ex_redirect;
   assign branch_target = ex_target;

   // Flush/jump are masked in reset so fetch sees a clean, free-running front end.
   always_comb begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b0;
      jump        = 1'b0;
      state_nxt   = state;
      cnt_nxt     = cnt;
      if (!rst) begin
         if (ex_redirect) begin
            if_id_flush = 1'b1;
            state_nxt   = RUN;
            cnt_nxt     = 3'd0;
         end else if (stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if (state == RUN) begin
               if (LOAD_USE_STALL > 1) begin
                  state_nxt = STALL;
                  cnt_nxt   = STALL_INIT;
               end
            end else if (cnt == 3'd1) begin
               state_nxt = RUN;
               cnt_nxt   = 3'd0;
            end else begin
               cnt_nxt = cnt - 3'd1;
            end
         end else if (jal_id) begin
            jump        = 1'b1;
            if_id_flush = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= RUN;
         cnt        <= 3'd0;
         idex_valid <= 1'b0;
         idex_instr <= NOP_INSTR;
         idex_pc    <= 32'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (ex_redirect || stall) begin
            idex_valid <= 1'b0;
            idex_instr <= NOP_INSTR;
            idex_pc    <= 32'd0;
         end else begin
            idex_valid <= 1'b1;
            idex_instr <= instr_in;
            idex_pc    <= pc_in;
         end
      end
   end

endmodule

// File: tb/tb_id_hazard_ctrl_pip.sv
// Directed bench: two instances (one- and three-cycle load-use stall) share stimulus.
module tb_id_hazard_ctrl_pip;

   localparam logic [31:0] NOP    = 32'h00000013;
   localparam logic [31:0] ADDI   = 32'h00500093;
   localparam logic [31:0] LW5    = 32'h00012283;
   localparam logic [31:0] ADD6   = 32'h00728333;
   localparam logic [31:0] ADD0   = 32'h00728033;
   localparam logic [31:0] LW0    = 32'h00012003;
   localparam logic [31:0] ADDX0  = 32'h00000333;
   localparam logic [31:0] JAL8   = 32'h0080006F;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr_in, pc_in, ex_target;
   logic        ex_redirect;

   logic        pw1, iw1, fl1, jp1, bt1, v1;
   logic [31:0] jt1, btg1, in1, pc1;
   logic        pw3, iw3, fl3, jp3, bt3, v3;
   logic [31:0] jt3, btg3, in3, pc3;

   int total = 0;
   int bad   = 0;
   int n;

   always #5 clk = ~clk;

   id_hazard_ctrl_pip #(.LOAD_USE_STALL(1)) u1 (
      .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in),
      .ex_redirect(ex_redirect), .ex_target(ex_target),
      .pc_write(pw1), .if_id_write(iw1), .if_id_flush(fl1), .jump(jp1), .jump_target(jt1),
      .branch_taken(bt1), .branch_target(btg1),
      .idex_valid(v1), .idex_instr(in1), .idex_pc(pc1));

   id_hazard_ctrl_pip #(.LOAD_USE_STALL(3)) u3 (
      .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in),
      .ex_redirect(ex_redirect), .ex_target(ex_target),
      .pc_write(pw3), .if_id_write(iw3), .if_id_flush(fl3), .jump(jp3), .jump_target(jt3),
      .branch_taken(bt3), .branch_target(btg3),
      .idex_valid(v3), .idex_instr(in3), .idex_pc(pc3));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs set afterwards settle before the #1 sample.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] i, input logic [31:0] p);
      instr_in = i;
      pc_in    = p;
      #1;
   endtask

   // Load in ID/EX, consumer held in IF/ID; count u3 cycles with pc_write low.
   task automatic count_stall(input logic [31:0] ld, input logic [31:0] use_i, output int cnt);
      drive(NOP, 32'h40);
      step();
      drive(ld, 32'h44);
      step();
      drive(use_i, 32'h48);
      cnt = 0;
      repeat (8) begin
         if (!pw3) cnt++;
         step();
         #1;
      end
   endtask

   initial begin
      rst = 1'b1; ex_redirect = 1'b0; ex_target = 32'h0;
      instr_in = ADDI; pc_in = 32'h0;
      #2;
      chk("rst_pc_write", 32'(pw1), 32'd1);
      chk("rst_if_id_write", 32'(iw1), 32'd1);
      chk("rst_flush", 32'(fl1), 32'd0);
      chk("rst_valid", 32'(v1), 32'd0);
      chk("rst_instr", in1, NOP);
      chk("rst_pc", pc1, 32'd0);
      #5 rst = 1'b0;
      step();
      chk("t1_valid", 32'(v1), 32'd1);
      chk("t1_instr", in1, ADDI);
      chk("t1_pc", pc1, 32'd0);
      chk("t1_pc_write", 32'(pw1), 32'd1);

      // Load-use with single-cycle stall
      drive(LW5, 32'h4);
      step();
      drive(ADD6, 32'h8);
      chk("t2_pw_stall", 32'(pw1), 32'd0);
      chk("t2_iw_stall", 32'(iw1), 32'd0);
      step();
      chk("t2_bubble_valid", 32'(v1), 32'd0);
      chk("t2_bubble_instr", in1, NOP);
      chk("t2_pw_resume", 32'(pw1), 32'd1);
      step();
      chk("t2_add_issued", in1, ADD6);
      chk("t2_add_pc", pc1, 32'h8);

      count_stall(LW5, ADD6, n);
      chk("t3_stall3", 32'(n), 32'd3);
      count_stall(LW5, ADD0, n);
      chk("t3_rd0_use_stalls", 32'(n), 32'd3);
      count_stall(LW0, ADDX0, n);
      chk("t3_lw_x0_nostall", 32'(n), 32'd0);

      // JAL in ID
      drive(JAL8, 32'h100);
      chk("t4_jump", 32'(jp1), 32'd1);
      chk("t4_target", jt1, 32'h108);
      chk("t4_flush", 32'(fl1), 32'd1);
      chk("t4_pc_write", 32'(pw1), 32'd1);
      step();
      chk("t4_idex_instr", in1, JAL8);
      chk("t4_idex_pc", pc1, 32'h100);
      chk("t4_idex_valid", 32'(v1), 32'd1);

      // Redirect during a STALL cycle on the three-cycle instance
      drive(LW5, 32'h4);
      step();
      drive(ADD6, 32'h8);
      step();
      chk("t5_in_stall", 32'(pw3), 32'd0);
      ex_redirect = 1'b1; ex_target = 32'h200;
      #1;
      chk("t5_branch_taken", 32'(bt3), 32'd1);
      chk("t5_branch_target", btg3, 32'h200);
      chk("t5_pc_write", 32'(pw3), 32'd1);
      chk("t5_flush", 32'(fl3), 32'd1);
      step();
      ex_redirect = 1'b0;
      #1;
      chk("t5_bubble", 32'(v3), 32'd0);
      chk("t5_back_to_run", 32'(pw3), 32'd1);

      // Redirect beats JAL in ID
      drive(JAL8, 32'h100);
      ex_redirect = 1'b1; ex_target = 32'h300;
      #1;
      chk("t6_jump_suppressed", 32'(jp1), 32'd0);
      chk("t6_branch", 32'(bt1), 32'd1);
      chk("t6_flush", 32'(fl1), 32'd1);
      step();
      ex_redirect = 1'b0;
      chk("t6_jal_not_loaded", 32'(v1), 32'd0);

      // Reset mid-STALL
      drive(LW5, 32'h4);
      step();
      drive(ADD6, 32'h8);
      step();
      chk("t6_pre_rst_stall", 32'(pw3), 32'd0);
      instr_in = JAL8;
      rst = 1'b1;
      #1;
      chk("t6_rst_pc_write", 32'(pw3), 32'd1);
      chk("t6_rst_if_id_write", 32'(iw3), 32'd1);
      chk("t6_rst_jump", 32'(jp3), 32'd0);
      chk("t6_rst_flush", 32'(fl3), 32'd0);
      chk("t6_rst_valid", 32'(v3), 32'd0);
      chk("t6_rst_instr", in3, NOP);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
